// File: rtl/audio_pkg.sv
// Shared audio definitions for the synth sample path: used by the note mixer
// and by the PWM output stage.
package audio_pkg;

  localparam int SAMPLE_W_DEFAULT = 8;

  localparam logic [SAMPLE_W_DEFAULT-1:0] MIDSCALE = {1'b1, {(SAMPLE_W_DEFAULT-1){1'b0}}};

  typedef logic [SAMPLE_W_DEFAULT-1:0] sample_t;

  // Midscale code for an arbitrary sample width (silence for an unsigned stream).
  function automatic int unsigned midscale_of(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/audio_pwm_out_sample_fifo.sv
// sample_fifo: small synchronous FIFO with circular pointers one bit wider than
// the index, so full and empty are told apart by the wr - rd difference.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int W_PTR = $clog2(DEPTH);
  localparam logic [W_PTR:0] DEPTH_CNT = (W_PTR+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [W_PTR:0]   wr_ptr;
  logic [W_PTR:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == DEPTH_CNT);
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[W_PTR-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[W_PTR-1:0]] <= push_data;
  end

endmodule

// File: rtl/audio_pwm_out.sv
// audio_pwm_out: buffers 8-bit samples and plays each one as a single PWM period.
// Optional AUDIO_PWM_UNDERRUN_CNT_EN adds a saturating underrun_count output.
module audio_pwm_out
  import audio_pkg::*;
#(
  parameter int SAMPLE_W   = SAMPLE_W_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [SAMPLE_W-1:0]           sample,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          pwm,
  output logic                          period_tick,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef AUDIO_PWM_UNDERRUN_CNT_EN
  ,
  output logic [7:0]                    underrun_count
`endif
);

  localparam logic [SAMPLE_W-1:0] CNT_MAX  = '1;
  localparam logic [SAMPLE_W-1:0] DUTY_RST = SAMPLE_W'(midscale_of(SAMPLE_W));

  logic [SAMPLE_W-1:0] cnt;
  logic [SAMPLE_W-1:0] duty;
  logic [SAMPLE_W-1:0] fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                boundary;
  logic                push;
  logic                pop;

  // Empty test uses the registered level, so a sample arriving on the boundary
  // cycle itself waits for the following boundary.
  assign boundary     = (cnt == CNT_MAX);
  assign sample_ready = !fifo_full;
  assign push         = sample_valid && sample_ready;
  assign pop          = boundary && !fifo_empty;
  assign period_tick  = boundary;
  assign underrun     = boundary && fifo_empty;

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (sample),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // The duty loaded at the boundary is in effect from cnt == 0, so the new
  // level reaches the pin one cycle after the wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      duty <= DUTY_RST;
      pwm  <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (pop) duty <= fifo_head;
      pwm <= (cnt < duty);
    end
  end

`ifdef AUDIO_PWM_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      underrun_count <= 8'd0;
    end else if (underrun && (underrun_count != 8'hFF)) begin
      underrun_count <= underrun_count + 8'd1;
    end
  end
`endif

endmodule
